axis_rr_arbiter: RTL and testbench



---
 rtl/axis_rr_arbiter_pkg.sv | 20 ++
 rtl/axis_rr_arbiter_rr_pick.sv | 40 ++++
 rtl/axis_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-level round-robin AXI-Stream arbiter.
package axis_rr_arbiter_pkg;

  // Arbiter FSM: IDLE waits for a request, XFER holds the grant until tlast.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Number of byte lanes carried by one beat (at least one lane).
  function automatic int keeps_of(input int width);
    return ((width / 8) > 0) ? (width / 8) : 1;
  endfunction

  // Index width for a given number of ports (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first request after 'last', wrapping
// around, using the double-width masked priority scan.
module rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter  int INPUTS = 4,
  localparam int IW     = idx_width(INPUTS)
) (
  input  logic [INPUTS-1:0] req,
  input  logic [IW-1:0]     last,
  output logic [INPUTS-1:0] gnt,
  output logic [IW-1:0]     idx,
  output logic              any
);

  logic [INPUTS-1:0]   w_mask;
  logic [2*INPUTS-1:0] w_dbl;
  int                  w_pos;

  // Lower half keeps only requests above 'last'; upper half is the wrapped copy,
  // so the lowest set bit of the doubled vector is the round-robin winner.
  always_comb begin
    w_mask = '0;
    gnt    = '0;
    for (int i = 0; i < INPUTS; i++) begin
      w_mask[i] = (i > int'(last));
    end
    w_dbl = {req, req & w_mask};
    w_pos = 0;
    for (int j = 2*INPUTS-1; j >= 0; j--) begin
      w_pos = w_dbl[j] ? (j % INPUTS) : w_pos;
    end
    any = |req;
    idx = IW'(w_pos);
    for (int k = 0; k < INPUTS; k++) begin
      gnt[k] = any & (k == w_pos);
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter with a registered output stage.
// A grant covers a whole packet; one idle cycle separates consecutive packets.
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int INPUTS = 4,
  parameter  int TKEEP  = 0,
  localparam int KEEPS  = keeps_of(WIDTH),
  localparam int ISB    = INPUTS - 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [INPUTS-1:0]         s_tvalid,
  output logic [INPUTS-1:0]         s_tready,
  input  logic [INPUTS*KEEPS-1:0]   s_tkeep,
  input  logic [INPUTS-1:0]         s_tlast,
  input  logic [INPUTS*WIDTH-1:0]   s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [KEEPS-1:0]          m_tkeep,
  output logic                      m_tlast,
  output logic [WIDTH-1:0]          m_tdata,
  output logic [INPUTS-1:0]         grant_o,
  output logic                      busy_o
);

  localparam int            IW       = idx_width(INPUTS);
  localparam logic [IW-1:0] LAST_RST = IW'(ISB);

  state_t              r_state;
  logic [INPUTS-1:0]   r_grant;
  logic [IW-1:0]       r_gidx;
  logic [IW-1:0]       r_last;
  logic                r_m_tvalid;
  logic                r_m_tlast;
  logic [WIDTH-1:0]    r_m_tdata;

  logic [INPUTS-1:0]   w_gnt;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic                w_beat_ok;
  logic                w_acc;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [WIDTH-1:0]    w_sel_data;
  logic [KEEPS-1:0]    w_sel_keep;

  rr_pick #(.INPUTS(INPUTS)) u_pick (
    .req  (s_tvalid),
    .last (r_last),
    .gnt  (w_gnt),
    .idx  (w_idx),
    .any  (w_any)
  );

  // AND-OR mux selecting the granted source's beat via the registered index.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = '0;
    for (int i = 0; i < INPUTS; i++) begin
      w_sel_valid = w_sel_valid | (s_tvalid[i] & (r_gidx == IW'(i)));
      w_sel_last  = w_sel_last  | (s_tlast[i]  & (r_gidx == IW'(i)));
      w_sel_data  = w_sel_data  | (s_tdata[i*WIDTH +: WIDTH] & {WIDTH{r_gidx == IW'(i)}});
      w_sel_keep  = w_sel_keep  | (s_tkeep[i*KEEPS +: KEEPS] & {KEEPS{r_gidx == IW'(i)}});
    end
  end

  // Granted source may push whenever the output register is empty or draining.
  always_comb begin
    if (r_state == ST_XFER) begin
      w_beat_ok = ~r_m_tvalid | m_tready;
    end else begin
      w_beat_ok = 1'b0;
    end
  end

  assign s_tready = w_beat_ok ? r_grant : '0;
  assign w_acc    = w_beat_ok & w_sel_valid;

  // Arbitration FSM: grant in IDLE, release after the accepted tlast beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= LAST_RST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_gnt;
            r_gidx  <= w_idx;
            r_last  <= w_idx;
            r_state <= ST_XFER;
          end else begin
            r_grant <= '0;
          end
        end
        ST_XFER: begin
          if (w_acc && w_sel_last) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_XFER;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: load an accepted beat, drop valid once downstream takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
    end else if (w_acc) begin
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_sel_last;
      r_m_tdata  <= w_sel_data;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end else begin
      r_m_tvalid <= r_m_tvalid;
    end
  end

  generate
    if (TKEEP != 0) begin : g_keep
      logic [KEEPS-1:0] r_m_tkeep;

      // Keep lanes travel alongside the data beat.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_m_tkeep <= '0;
        end else if (w_acc) begin
          r_m_tkeep <= w_sel_keep;
        end else begin
          r_m_tkeep <= r_m_tkeep;
        end
      end

      assign m_tkeep = r_m_tkeep;
    end else begin : g_nokeep
      logic w_unused_keep;
      assign w_unused_keep = ^w_sel_keep;
      assign m_tkeep       = '0;
    end
  endgenerate

  assign m_tvalid = r_m_tvalid;
  assign m_tlast  = r_m_tlast;
  assign m_tdata  = r_m_tdata;
  assign grant_o  = r_grant;
  assign busy_o   = (r_state == ST_XFER);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: a packet-level behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_axis_rr_arbiter;

  typedef struct packed { logic last; logic [7:0] data; } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // 8-bit, TKEEP=0 instance
  logic [3:0]  s_tvalid = 4'b0, s_tlast = 4'b0, s_tkeep = 4'b0, s_tready;
  logic [31:0] s_tdata  = 32'h0;
  logic        m_tready = 1'b1;
  logic        m_tvalid, m_tlast, busy_o;
  logic [0:0]  m_tkeep;
  logic [7:0]  m_tdata;
  logic [3:0]  grant_o;

  // 32-bit, TKEEP=1 instance
  logic [3:0]   k_s_tvalid = 4'b0, k_s_tlast = 4'b0, k_s_tready;
  logic [15:0]  k_s_tkeep = 16'h0;
  logic [127:0] k_s_tdata = 128'h0;
  logic         k_m_tready = 1'b1;
  logic         k_m_tvalid, k_m_tlast, k_busy;
  logic [3:0]   k_m_tkeep, k_grant;
  logic [31:0]  k_m_tdata;

  axis_rr_arbiter dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tdata(m_tdata),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  axis_rr_arbiter #(.WIDTH(32), .INPUTS(4), .TKEEP(1)) dut_k (
    .clock(clock), .reset(reset),
    .s_tvalid(k_s_tvalid), .s_tready(k_s_tready), .s_tkeep(k_s_tkeep),
    .s_tlast(k_s_tlast), .s_tdata(k_s_tdata),
    .m_tvalid(k_m_tvalid), .m_tready(k_m_tready), .m_tkeep(k_m_tkeep),
    .m_tlast(k_m_tlast), .m_tdata(k_m_tdata),
    .grant_o(k_grant), .busy_o(k_busy)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model (packet-level rules) ----------------
  bit         md_busy = 1'b0;
  int         md_g    = 0;
  int         md_last = 3;
  bit         md_mv   = 1'b0;
  bit         md_ml   = 1'b0;
  logic [7:0] md_data = 8'h00;

  always @(posedge clock) begin : model_upd
    int pick;
    bit acc;
    acc = md_busy && (!md_mv || m_tready) && s_tvalid[md_g];
    if (reset) begin
      md_busy <= 1'b0; md_g <= 0; md_last <= 3;
      md_mv <= 1'b0; md_ml <= 1'b0; md_data <= 8'h00;
    end else begin
      if (acc) begin
        md_mv <= 1'b1; md_ml <= s_tlast[md_g]; md_data <= s_tdata[md_g*8 +: 8];
      end else if (m_tready) begin
        md_mv <= 1'b0;
      end
      if (!md_busy) begin
        pick = -1;
        for (int k = 1; k <= 4; k++)
          if (pick < 0 && s_tvalid[(md_last + k) % 4]) pick = (md_last + k) % 4;
        if (pick >= 0) begin
          md_busy <= 1'b1; md_g <= pick; md_last <= pick;
        end
      end else if (acc && s_tlast[md_g]) begin
        md_busy <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin : compare
    logic [3:0] eg, er;
    if (cmp_en) begin
      eg = md_busy ? (4'b0001 << md_g) : 4'b0000;
      er = (md_busy && (!md_mv || m_tready)) ? eg : 4'b0000;
      chk("model_grant",  grant_o,  eg);
      chk("model_busy",   busy_o,   md_busy);
      chk("model_ready",  s_tready, er);
      chk("model_mvalid", m_tvalid, md_mv);
      chk("model_mdata",  m_tdata,  md_data);
      chk("model_mlast",  m_tlast,  md_ml);
      chk("model_mkeep",  m_tkeep,  1'b0);
    end
  end

  // ---------------- source drivers ----------------
  beat_t      srcq [4][$];
  logic [3:0] hold = 4'b0;
  logic [3:0] hs;

  task automatic push_pkt(input int i, input int n, input int base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.last = (k == n - 1);
      b.data = 8'(base + k);
      srcq[i].push_back(b);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() > 0 && !hold[i]) begin
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = srcq[i][0].last;
        s_tdata[i*8 +: 8] = srcq[i][0].data;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tdata[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // One clock: capture handshakes, then advance sources just after the edge.
  task automatic cyc();
    @(negedge clock);
    hs = s_tvalid & s_tready;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    apply();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold  = 4'b0;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    apply();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  int         order [$];
  logic [3:0] prev_g;
  bit         tv [0:39];
  int         first_beat, mism, nbeats;
  logic [7:0] got [$];
  bit         prev_stall;
  logic [7:0] prev_data;
  logic [19:0] ord5;

  initial begin
    do_reset();
    cmp_en = 1'b1;
    chk("rst_mvalid", m_tvalid, 1'b0);
    chk("rst_grant",  grant_o,  4'b0000);
    chk("rst_ready",  s_tready, 4'b0000);
    chk("rst_busy",   busy_o,   1'b0);
    chk("rst_mdata",  m_tdata,  8'h00);
    chk("rst_mlast",  m_tlast,  1'b0);

    // Test 1: 3-beat packet on input 2
    push_pkt(2, 3, 8'h11);
    srcq[2][1].data = 8'h22;
    srcq[2][2].data = 8'h33;
    apply();
    cyc();
    chk("t1_grant_c1", grant_o, 4'b0100);
    chk("t1_ready_c1", s_tready, 4'b0100);
    cyc();
    chk("t1_valid_c2", m_tvalid, 1'b1);
    chk("t1_data_c2",  m_tdata, 8'h11);
    chk("t1_last_c2",  m_tlast, 1'b0);
    cyc();
    chk("t1_data_c3",  m_tdata, 8'h22);
    chk("t1_last_c3",  m_tlast, 1'b0);
    cyc();
    chk("t1_data_c4",  m_tdata, 8'h33);
    chk("t1_last_c4",  m_tlast, 1'b1);
    cyc();
    chk("t1_grant_c5", grant_o, 4'b0000);
    chk("t1_valid_c5", m_tvalid, 1'b0);

    // Test 2: all inputs with two 2-beat packets each
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < 2; p++) push_pkt(i, 2, i*16 + p*4);
    apply();
    prev_g = 4'b0;
    for (int c = 1; c < 40; c++) begin
      cyc();
      if (grant_o != 4'b0 && prev_g == 4'b0)
        for (int k = 0; k < 4; k++) if (grant_o[k]) order.push_back(k);
      prev_g = grant_o;
      tv[c]  = m_tvalid;
    end
    ord5 = {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]};
    chk("t2_grant_order", ord5, 20'h01230);
    first_beat = -1; nbeats = 0; mism = 0;
    for (int c = 1; c < 40; c++) begin
      if (tv[c]) nbeats++;
      if (tv[c] && first_beat < 0) first_beat = c;
    end
    chk("t2_first_beat", first_beat, 2);
    chk("t2_beat_count", nbeats, 16);
    for (int k = 0; k < 23; k++)
      if (first_beat >= 0 && tv[first_beat + k] != ((k % 3) != 2)) mism++;
    chk("t2_bubble_pattern", mism, 0);

    // Test 3: m_tready toggling during a 4-beat packet on input 0
    do_reset();
    push_pkt(0, 4, 8'hA0);
    apply();
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int c = 1; c < 24; c++) begin
      cyc();
      m_tready = c[0];
      if (prev_stall) chk("t3_stall_hold", m_tdata, prev_data);
      if (m_tvalid && m_tready) got.push_back(m_tdata);
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
    m_tready = 1'b1;
    chk("t3_beats", got.size(), 4);
    for (int k = 0; k < 4; k++) chk("t3_order", got[k], 8'hA0 + 8'(k));

    // Test 4: input 0 requests while input 1 is mid-packet
    do_reset();
    push_pkt(1, 4, 8'h50);
    apply();
    cyc();
    chk("t4_grant_c1", grant_o, 4'b0010);
    push_pkt(0, 2, 8'h70);
    apply();
    cyc();
    hold[1] = 1'b1;
    apply();
    chk("t4_ready0_c2", s_tready[0], 1'b0);
    cyc();
    hold[1] = 1'b0;
    apply();
    chk("t4_ready0_c3", s_tready[0], 1'b0);
    chk("t4_grant_c3",  grant_o, 4'b0010);
    cyc();
    chk("t4_ready0_c4", s_tready[0], 1'b0);
    cyc();
    chk("t4_ready0_c5", s_tready[0], 1'b0);
    cyc();
    chk("t4_gap_grant", grant_o, 4'b0000);
    chk("t4_gap_ready", s_tready, 4'b0000);
    cyc();
    chk("t4_grant_c7", grant_o, 4'b0001);
    chk("t4_ready_c7", s_tready, 4'b0001);
    for (int c = 0; c < 5; c++) cyc();

    // Test 5: reset pulsed on the second beat of a packet
    do_reset();
    push_pkt(2, 3, 8'h90);
    apply();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    apply();
    chk("t5_mvalid", m_tvalid, 1'b0);
    chk("t5_grant",  grant_o, 4'b0000);
    chk("t5_busy",   busy_o,  1'b0);
    push_pkt(0, 1, 8'hC0);
    push_pkt(3, 1, 8'hC3);
    apply();
    cyc();
    chk("t5_first_grant", grant_o, 4'b0001);
    for (int c = 0; c < 8; c++) cyc();

    // Test 6: 32-bit TKEEP=1 instance, input 3, partial keep on tlast beat
    do_reset();
    k_s_tvalid = 4'b1000;
    k_s_tdata[96 +: 32] = 32'hDEADBEEF;
    k_s_tkeep[12 +: 4]  = 4'b1111;
    k_s_tlast = 4'b0000;
    cyc();
    chk("t6_grant", k_grant, 4'b1000);
    cyc();
    k_s_tdata[96 +: 32] = 32'hCAFE0123;
    k_s_tkeep[12 +: 4]  = 4'b0111;
    k_s_tlast = 4'b1000;
    chk("t6_valid_b0", k_m_tvalid, 1'b1);
    chk("t6_data_b0",  k_m_tdata, 32'hDEADBEEF);
    chk("t6_keep_b0",  k_m_tkeep, 4'b1111);
    chk("t6_last_b0",  k_m_tlast, 1'b0);
    cyc();
    k_s_tvalid = 4'b0000;
    k_s_tlast  = 4'b0000;
    chk("t6_data_b1",  k_m_tdata, 32'hCAFE0123);
    chk("t6_keep_b1",  k_m_tkeep, 4'b0111);
    chk("t6_last_b1",  k_m_tlast, 1'b1);
    chk("t6_grant_end", k_grant, 4'b0000);
    cyc();
    chk("t6_valid_end", k_m_tvalid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
